// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch/sequencer FSM.
//   clk, rst       : single clock, synchronous active-high reset
//   start          : begin execution at address 0 (honoured in IDLE / HALT)
//   mem_addr/mem_rd: instruction memory read port, data returns one cycle later
//   mem_data       : instruction word from memory
//   instr, pc      : current instruction and program counter to the branch stage
//   pc_new, runo   : branch-stage target and status (runo=0 -> target resolved)
//   exec_done      : datapath finished a non-branch instruction
//   run, halted    : executing / stopped on HALT_WORD
//   retired        : saturating count of completed instructions
module fetch_unit #(
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [7:0]  pc,
  input  logic [7:0]  pc_new,
  input  logic        runo,
  input  logic        exec_done,
  output logic        run,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_q;     // last address put on the memory bus
  logic        restart;    // start accepted from IDLE/HALT
  logic        retire;     // current instruction completes this cycle
  logic        is_branch;

  assign is_branch = (instr[1:0] == 2'b10);

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    run       = 1'b0;
    halted    = 1'b0;
    restart   = 1'b0;
    retire    = 1'b0;
    // address is live while strobing, otherwise it holds the last fetch
    mem_addr  = (state == FETCH) ? pc : addr_q;
    case (state)
      IDLE: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        // halt word wins over any format decode of the same word
        state_nxt = (mem_data == HALT_WORD) ? HALT : EXEC;
      end
      EXEC: begin
        run = 1'b1;
        // branches complete on runo=0 only; exec_done is irrelevant for them
        if (is_branch ? !runo : exec_done) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (start) begin
          restart   = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= 8'h00;
      instr   <= 16'h0000;
      addr_q  <= 8'h00;
      retired <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (restart) begin
        pc      <= 8'h00;
        retired <= 16'h0000;
      end
      if (state == FETCH) addr_q <= pc;
      if (state == LOAD)  instr  <= mem_data;
      if (retire) begin
        pc      <= is_branch ? pc_new : pc + 8'd1;
        retired <= (retired == 16'hFFFF) ? retired : retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against a
// cycle-accurate behavioural model of the fetch/exec timeline.
module tb_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst, start, runo, exec_done, mem_rd, run, halted;
  logic [7:0]  mem_addr, pc, pc_new;
  logic [15:0] mem_data, instr, retired;

  fetch_unit #(.HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .instr(instr), .pc(pc), .pc_new(pc_new), .runo(runo),
    .exec_done(exec_done), .run(run), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [7:0]  fetched [$];
  int n_cmp = 0, n_bad = 0;

  // memory: data valid the cycle after the strobe, junk otherwise
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 16'($urandom);

  always @(negedge clk) if (mem_rd === 1'b1) fetched.push_back(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction's life is measured as its age in cycles since its fetch
  // strobe: age 0 fetch, age 1 word arrives, age >= 2 executing.
  logic        m_active = 1'b0, m_halt = 1'b0, armed = 1'b0;
  int          m_age = 0;
  logic [7:0]  m_pc = 8'h00, m_addr = 8'h00;
  logic [15:0] m_instr = 16'h0, m_ret = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0; m_halt <= 1'b0; m_age <= 0; m_pc <= 8'h00;
      m_addr <= 8'h00; m_instr <= 16'h0; m_ret <= 16'h0; armed <= 1'b1;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_halt <= 1'b0; m_age <= 0; m_pc <= 8'h00; m_ret <= 16'h0;
      end
    end else if (m_age == 0) begin
      m_addr <= m_pc; m_age <= 1;
    end else if (m_age == 1) begin
      m_instr <= mem[m_addr];
      if (mem[m_addr] == HALT) begin m_active <= 1'b0; m_halt <= 1'b1; end
      else m_age <= 2;
    end else if ((m_instr[1:0] == 2'b10) ? !runo : exec_done) begin
      m_pc  <= (m_instr[1:0] == 2'b10) ? pc_new : m_pc + 8'd1;
      m_ret <= (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // compare every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (armed) begin
      chk("mem_rd",   {31'b0, mem_rd},  {31'b0, m_active && m_age == 0});
      chk("mem_addr", {24'b0, mem_addr}, {24'b0, (m_active && m_age == 0) ? m_pc : m_addr});
      chk("run",      {31'b0, run},     {31'b0, m_active && m_age >= 2});
      chk("halted",   {31'b0, halted},  {31'b0, m_halt});
      chk("pc",       {24'b0, pc},      {24'b0, m_pc});
      chk("instr",    {16'b0, instr},   {16'b0, m_instr});
      chk("retired",  {16'b0, retired}, {16'b0, m_ret});
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // sel 1 = halted, else run
  task automatic wait_for(input string name, input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 1) ? halted : run) break;
      @(negedge clk);
    end
    chk(name, {31'b0, (sel == 1) ? halted : run}, 32'd1);
  endtask

  task automatic wait_fetches(input int n, input int budget);
    for (int i = 0; i < budget && fetched.size() < n; i++) @(negedge clk);
    chk("fetch_count", fetched.size(), n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; runo = 1'b1; exec_done = 1'b0; pc_new = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_pc", {24'b0, pc}, 32'h0);
    chk("rst_instr", {16'b0, instr}, 32'h0);
    chk("rst_run", {31'b0, run}, 32'h0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // sequential program ending in HALT
    mem[0] = 16'h0001; mem[1] = 16'h0005; mem[2] = HALT;
    exec_done = 1'b1; runo = 1'b1;
    fetched.delete();
    pulse_start();
    wait_for("seq_halt", 1, 40);
    chk("seq_retired", {16'b0, retired}, 32'd2);
    chk("seq_pc", {24'b0, pc}, 32'h02);
    chk("seq_instr", {16'b0, instr}, 32'hFFFF);
    chk("seq_nfetch", fetched.size(), 3);
    if (fetched.size() == 3) begin
      chk("seq_a0", {24'b0, fetched[0]}, 32'h00);
      chk("seq_a1", {24'b0, fetched[1]}, 32'h01);
      chk("seq_a2", {24'b0, fetched[2]}, 32'h02);
    end

    // branch taken, exec_done high but irrelevant
    mem[0] = 16'h0532; mem[8'h53] = HALT;
    runo = 1'b0; pc_new = 8'h53; exec_done = 1'b1;
    fetched.delete();
    pulse_start();
    wait_for("br_halt", 1, 40);
    chk("br_retired", {16'b0, retired}, 32'd1);
    chk("br_pc", {24'b0, pc}, 32'h53);
    if (fetched.size() == 2) chk("br_target", {24'b0, fetched[1]}, 32'h53);
    else chk("br_nfetch", fetched.size(), 2);

    // branch stall: runo high for four exec cycles
    mem[0] = 16'h0012; mem[8'h10] = HALT;
    runo = 1'b1; pc_new = 8'h77; exec_done = 1'b1;
    pulse_start();
    wait_for("stall_run_rise", 0, 10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_run", {31'b0, run}, 32'd1);
      if (i == 4) begin runo = 1'b0; pc_new = 8'h10; end
      @(negedge clk);
    end
    chk("stall_run_fall", {31'b0, run}, 32'd0);
    chk("stall_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("stall_addr", {24'b0, mem_addr}, 32'h10);
    wait_for("stall_halt", 1, 10);

    // pc wrap: 0 -> branch FF -> non-branch -> 00
    mem[0] = 16'h0002; mem[8'hFF] = 16'h0001;
    runo = 1'b0; pc_new = 8'hFF; exec_done = 1'b1;
    fetched.delete();
    pulse_start();
    wait_fetches(3, 30);
    if (fetched.size() >= 3) begin
      chk("wrap_a1", {24'b0, fetched[1]}, 32'hFF);
      chk("wrap_a2", {24'b0, fetched[2]}, 32'h00);
    end

    // reset while executing
    wait_for("rst_exec_run", 0, 10);
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_pc", {24'b0, pc}, 32'h0);
    chk("rstx_instr", {16'b0, instr}, 32'h0);
    chk("rstx_ret", {16'b0, retired}, 32'h0);
    chk("rstx_addr", {24'b0, mem_addr}, 32'h0);
    chk("rstx_flags", {28'b0, mem_rd, run, halted, 1'b0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstx_idle", {30'b0, run, mem_rd}, 32'h0);

    // start during EXEC is ignored
    mem[0] = 16'h0001; mem[1] = HALT;
    runo = 1'b1; exec_done = 1'b0;
    fetched.delete();
    pulse_start();
    wait_for("ign_run", 0, 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_pc", {24'b0, pc}, 32'h0);
    chk("ign_ret", {16'b0, retired}, 32'h0);
    chk("ign_still_run", {31'b0, run}, 32'd1);
    exec_done = 1'b1;
    wait_for("ign_halt", 1, 20);
    chk("ign_final_ret", {16'b0, retired}, 32'd1);
    chk("ign_final_pc", {24'b0, pc}, 32'h01);
    chk("ign_nfetch", fetched.size(), 2);

    // randomized run, model checks every cycle
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 24) == 0) ? HALT : 16'($urandom);
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      runo      = ($urandom_range(0, 2) != 0);
      exec_done = ($urandom_range(0, 2) == 0);
      pc_new    = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter HALT_WORD, default 16'hFFFF, instruction word that stops the sequencer.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin execution at address 8'h00; sampled in IDLE and HALT only.
REQ-005 mem_addr  output  8  instruction memory read address.
REQ-006 mem_rd  output  1  read strobe; mem_data valid exactly one cycle after the strobe.
REQ-007 mem_data  input  16  instruction word from memory.
REQ-008 instr  output  16  instruction register, drives branch-stage instruction input.
REQ-009 pc  output  8  current program counter, drives branch-stage pc input.
REQ-010 pc_new  input  8  next-PC from branch stage.
REQ-011 runo  input  1  branch-stage status; 0 = branch stage resolved pc_new for this instruction.
REQ-012 exec_done  input  1  datapath completed a non-branch instruction.
REQ-013 run  output  1  instr valid and executing (EXEC state).
REQ-014 halted  output  1  high while in HALT.
REQ-015 retired  output  16  count of completed instructions, saturating.

Function
REQ-016 FSM states: IDLE, FETCH, LOAD, EXEC, HALT; encoding free.
REQ-017 IDLE: outputs quiescent; start=1 -> pc<=8'h00, retired<=0, next FETCH.
REQ-018 FETCH: mem_rd=1, mem_addr=pc; next LOAD unconditionally.
REQ-019 LOAD: mem_rd=0; instr<=mem_data; next EXEC, or HALT if mem_data==HALT_WORD (instr still loaded).
REQ-020 EXEC: run=1; mem_rd=0; pc and instr held stable.
REQ-021 EXEC, instr[1:0]==2'b10 and runo==0: pc<=pc_new, retired increments, next FETCH; exec_done ignored.
REQ-022 EXEC, instr[1:0]==2'b10 and runo==1: remain in EXEC (wait for branch stage).
REQ-023 EXEC, instr[1:0]!=2'b10: wait for exec_done=1; then pc<=pc+1 (mod 256), retired increments, next FETCH.
REQ-024 PC wrap: pc 8'hFF incremented yields 8'h00; no flag, no stall.
REQ-025 retired saturates at 16'hFFFF; no wrap.
REQ-026 Latency: FETCH-entry to run=1 is exactly 2 cycles; instruction-to-instruction minimum 3 cycles.
REQ-027 HALT: halted=1, run=0, mem_rd=0, pc/instr/retired held; start=1 -> pc<=8'h00, retired<=0, next FETCH.
REQ-028 start in FETCH, LOAD, EXEC ignored.
REQ-029 mem_addr holds last driven pc value when mem_rd=0.
REQ-030 HALT_WORD check has priority over format decode.

Reset
REQ-031 rst=1 at any edge, any state (incl. mid-fetch or mid-EXEC): state<=IDLE, pc=8'h00, instr=16'h0000, mem_addr=8'h00, mem_rd=0, run=0, halted=0, retired=16'h0000.
REQ-032 rst has priority over start, exec_done, runo; in-flight memory data is discarded.
REQ-033 First cycle after rst deasserts: IDLE; start sampled from that cycle.

Verification
REQ-034 Sequential: mem[0..2]=16'h0001,16'h0005,HALT_WORD, exec_done=1 one cycle after each run rise -> addresses 0,1,2 fetched, halted=1, retired=2, pc=8'h02.
REQ-035 Branch taken: mem[0]=16'h0532 (format 10), runo=0, pc_new=8'h53 -> next mem_addr=8'h53, retired=1, exec_done ignored.
REQ-036 Branch stall: format-10 instr, runo=1 for 4 cycles then 0 with pc_new=8'h10 -> run=1 for 5 cycles, then fetch at 8'h10.
REQ-037 Wrap: branch to 8'hFF, non-branch instr, exec_done -> next fetch address 8'h00.
REQ-038 Reset mid-EXEC: rst=1 while run=1 -> next cycle all outputs at reset values, state IDLE; start restarts at 8'h00.
REQ-039 Start ignored: start pulsed during EXEC -> pc and retired unchanged, execution continues normally.
